bcd_run_ctrl: RTL and testbench

Run controller for a 2-digit BCD event counter: it sequences counting with start/stop/clear commands, divides the system clock into count ticks, and stops on a programmable BCD target. Sits between the front-panel command pulses and the 7-segment display path, and owns the count register `q` and the `max_tick` terminal pulse.

---
 rtl/bcd_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bcd_run_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_run_ctrl.sv
// rtl/bcd_run_ctrl.sv - run controller for a 2-digit BCD event counter
//
// Purpose: sequences counting with start/stop/clear command pulses, divides
// clk by PRESC_DIV into count ticks, and halts when the BCD count reaches a
// programmable BCD target.
//
// Parameters:
//   PRESC_DIV  clock cycles per count increment (>= 2)
//   TARGET     reset value of the BCD target register
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-low reset
//   start      command pulse: run / resume / restart from DONE
//   stop       command pulse: pause while running
//   clear      command pulse: zero the count, go idle
//   tgt_load   load tgt_in into the target (IDLE only, valid BCD only)
//   tgt_in     new BCD target
//   q          BCD count, tens [7:4], units [3:0]
//   tick       one-cycle pulse when q shows a new value
//   max_tick   one-cycle pulse when q first equals the target
//   state      FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   busy       high while state is RUN
//
// Build option: BCD_AUTO_RELOAD_EN - on reaching the target keep running and
// reload q to 00 at the next prescaler wrap instead of halting in DONE.
module bcd_run_ctrl #(
  parameter int unsigned PRESC_DIV = 10,
  parameter logic [7:0]  TARGET    = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       tgt_load,
  input  logic [7:0] tgt_in,
  output logic [7:0] q,
  output logic       tick,
  output logic       max_tick,
  output logic [1:0] state,
  output logic       busy
);

  localparam int unsigned   PW         = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    tgt_q, tgt_d;
  logic          tick_q, tick_d;
  logic          max_q, max_d;
  logic          busy_q, busy_d;
`ifdef BCD_AUTO_RELOAD_EN
  // Set when the target was just shown; the next wrap reloads 00.
  logic          reload_q, reload_d;
`endif

  logic [7:0] cnt_inc;
  logic       tgt_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign cnt_inc = bcd_inc(cnt_q);
  assign tgt_ok  = (tgt_in[7:4] <= 4'd9) && (tgt_in[3:0] <= 4'd9);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    tick_d  = 1'b0;
    max_d   = 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (tgt_load && (state_q == IDLE) && tgt_ok) begin
      tgt_d = tgt_in;
    end

    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = 8'h00;
`ifdef BCD_AUTO_RELOAD_EN
      reload_d = 1'b0;
`endif
    end else begin
      // stop outranks start, so a start alongside stop is dropped
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
            if (reload_q) begin
              cnt_d    = 8'h00;
              reload_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == tgt_q) begin
                max_d    = 1'b1;
                reload_d = 1'b1;
              end
            end
`else
            cnt_d = cnt_inc;
            if (cnt_inc == tgt_q) begin
              max_d   = 1'b1;
              state_d = DONE;
            end
`endif
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start && !stop) begin
            state_d = RUN;
            presc_d = '0;
            cnt_d   = 8'h00;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_q   <= 8'h00;
      tgt_q   <= TARGET;
      tick_q  <= 1'b0;
      max_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BCD_AUTO_RELOAD_EN
      reload_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      tick_q  <= tick_d;
      max_q   <= max_d;
      busy_q  <= busy_d;
`ifdef BCD_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q        = cnt_q;
  assign tick     = tick_q;
  assign max_tick = max_q;
  assign state    = state_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// tb/tb_bcd_run_ctrl.sv - scoreboard bench for bcd_run_ctrl
module tb_bcd_run_ctrl;

  localparam int         DIV  = 4;
  localparam logic [7:0] TGT0 = 8'h12;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic       clear    = 1'b0;
  logic       tgt_load = 1'b0;
  logic [7:0] tgt_in   = 8'h00;
  logic [7:0] q;
  logic       tick;
  logic       max_tick;
  logic [1:0] state;
  logic       busy;

  bcd_run_ctrl #(.PRESC_DIV(DIV), .TARGET(TGT0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .tgt_load (tgt_load),
    .tgt_in   (tgt_in),
    .q        (q),
    .tick     (tick),
    .max_tick (max_tick),
    .state    (state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       tick;
    logic       max_tick;
    logic [1:0] state;
    logic       busy;
  } snap_t;

  snap_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: count and target held as plain decimal integers.
  int m_mode     = M_IDLE;
  int m_cnt      = 0;
  int m_elapsed  = 0;
  int m_tgt      = 12;
  bit m_reload   = 1'b0;
  bit m_last_max = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic count_period(output bit e_tick, output bit e_max);
    e_tick = 1'b0;
    e_max  = 1'b0;
    if (m_elapsed == DIV - 1) begin
      m_elapsed = 0;
      e_tick    = 1'b1;
      if (m_reload) begin
        m_cnt    = 0;
        m_reload = 1'b0;
      end else begin
        m_cnt = (m_cnt + 1) % 100;
        if (m_cnt == m_tgt) begin
          e_max = 1'b1;
`ifdef BCD_AUTO_RELOAD_EN
          m_reload = 1'b1;
`else
          m_mode = M_DONE;
`endif
        end
      end
    end else begin
      m_elapsed++;
    end
  endtask

  task automatic model_step(input bit rst_n, input bit s, input bit st,
                            input bit cl, input bit tl, input logic [7:0] ti);
    bit    e_tick;
    bit    e_max;
    int    new_tgt;
    snap_t e;
    e_tick  = 1'b0;
    e_max   = 1'b0;
    new_tgt = m_tgt;
    if (!rst_n) begin
      m_mode    = M_IDLE;
      m_cnt     = 0;
      m_elapsed = 0;
      m_reload  = 1'b0;
      new_tgt   = 12;
    end else begin
      if (tl && m_mode == M_IDLE && ti[7:4] < 4'd10 && ti[3:0] < 4'd10)
        new_tgt = int'(ti[7:4]) * 10 + int'(ti[3:0]);
      if (cl) begin
        m_mode    = M_IDLE;
        m_cnt     = 0;
        m_elapsed = 0;
        m_reload  = 1'b0;
      end else if (st) begin
        if (m_mode == M_RUN) m_mode = M_PAUSE;
      end else if (m_mode == M_RUN) begin
        count_period(e_tick, e_max);
      end else if (s) begin
        if (m_mode == M_IDLE) begin
          m_elapsed = 0;
        end else if (m_mode == M_DONE) begin
          m_cnt     = 0;
          m_elapsed = 0;
        end
        m_mode = M_RUN;
      end
    end
    m_tgt      = new_tgt;
    m_last_max = e_max;
    e.q        = to_bcd(m_cnt);
    e.tick     = e_tick;
    e.max_tick = e_max;
    e.state    = 2'(m_mode);
    e.busy     = (m_mode == M_RUN);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst_n, input bit s, input bit st,
                       input bit cl, input bit tl, input logic [7:0] ti);
    @(negedge clk);
    reset    = rst_n;
    start    = s;
    stop     = st;
    clear    = cl;
    tgt_load = tl;
    tgt_in   = ti;
    model_step(rst_n, s, st, cl, tl, ti);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_until_max(input int limit);
    int i;
    i = 0;
    idle(1);
    while (!m_last_max && i < limit) begin
      idle(1);
      i++;
    end
    if (!m_last_max) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_until_max: got no target hit within %0d cycles, required a hit", limit);
    end
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare against
  // the oldest expected snapshot.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.q        = q;
        a.tick     = tick;
        a.max_tick = max_tick;
        a.state    = state;
        a.busy     = busy;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check @%0t: got q=%h tick=%b max_tick=%b state=%b busy=%b, expected q=%h tick=%b max_tick=%b state=%b busy=%b",
                   $time, a.q, a.tick, a.max_tick, a.state, a.busy,
                   e.q, e.tick, e.max_tick, e.state, e.busy);
        end
      end
    end
  end

  initial begin
    int k;
    // reset low two cycles, then release
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);

    // count 01..12 then halt
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_until_max(200);
    idle(6);

    // stop exactly in the wrap cycle at q=05, then resume
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    k = 0;
    while (!(m_cnt == 5 && m_elapsed == DIV - 1 && m_mode == M_RUN) && k < 200) begin
      idle(1);
      k++;
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);

    // all three commands together while running
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    idle(2);

    // invalid target ignored; run still ends at 12
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1A);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_until_max(200);

    // target 00 reached on the 99->00 wrap
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_until_max(600);
    idle(2);

    // restart from DONE, load attempt during RUN is ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02);
    run_until_max(600);

    // small target; with auto reload this keeps cycling
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);

    // reset mid-run restores the default target
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_until_max(200);

    // randomized commands, one at a time
    for (int i = 0; i < 2500; i++) begin
      int         r;
      logic [7:0] ti;
      r  = $urandom_range(0, 199);
      ti = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 99)));
      if (r < 6)       drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      else if (r < 9)  drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      else if (r < 11) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      else if (r < 16) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ti);
      else if (r == 16) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      else             idle(1);
    end

    @(negedge clk);
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; tgt_load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked snapshots, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
